// File: rtl/iagc_pkg.sv
// Shared types and constants for the IAGC error generator: FSM encoding,
// default data width, error saturation limits and accumulator sizing.
package iagc_pkg;

   localparam int unsigned DATA_SIZE_DEF = 14;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_CALC,
      ST_ISSUE,
      ST_WAIT
   } state_e;

   // Largest and smallest two's-complement values of a w-bit error
   function automatic int err_max_f(input int unsigned w);
      return (2 ** (w - 1)) - 1;
   endfunction

   function automatic int err_min_f(input int unsigned w);
      return -(2 ** (w - 1));
   endfunction

   localparam int ERR_MAX = err_max_f(DATA_SIZE_DEF);
   localparam int ERR_MIN = err_min_f(DATA_SIZE_DEF);

   // Accumulator wide enough to sum 2^avg_log2 full-scale samples
   function automatic int unsigned acc_width(input int unsigned data_size,
                                             input int unsigned avg_log2);
      return data_size + avg_log2;
   endfunction

endpackage

// File: rtl/iagc_sample_avg.sv
// Block averager: sums 2^AVG_LOG2 qualified samples and flags the cycle
// that accepts the last one of the block.
module iagc_sample_avg
   import iagc_pkg::*;
#(
   parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
   parameter int unsigned AVG_LOG2  = 4
)(
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 clear,
   input  logic                 accum_en,
   input  logic [DATA_SIZE-1:0] sample,
   input  logic                 sample_valid,
   output logic [DATA_SIZE-1:0] avg,
   output logic                 done_c
);

   localparam int unsigned ACC_W = acc_width(DATA_SIZE, AVG_LOG2);
   localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

   logic [ACC_W-1:0] acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             take_c;

   assign take_c = accum_en & sample_valid;
   assign done_c = take_c & (cnt_q == CNT_W'((2 ** AVG_LOG2) - 1));
   assign avg    = acc_q[ACC_W-1 -: DATA_SIZE];

   // Counter wraps to zero on the final sample, ready for the next block
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else if (clear) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else if (take_c) begin
         acc_q <= acc_q + ACC_W'(sample);
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/iagc_error_gen.sv
// IAGC error generator: averages envelope blocks, forms a saturated
// reference-minus-average error and handshakes it to the divider.
// Optional WAIT watchdog enabled by IAGC_ERRGEN_TIMEOUT_EN.
module iagc_error_gen
   import iagc_pkg::*;
#(
   parameter int unsigned DATA_SIZE      = DATA_SIZE_DEF,
   parameter int unsigned AVG_LOG2       = 4,
   parameter int unsigned START_HOLD     = 10,
   parameter int unsigned TIMEOUT_CYCLES = 1024
)(
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_enable,
   input  logic [DATA_SIZE-1:0] i_sample,
   input  logic                 i_sample_valid,
   input  logic [DATA_SIZE-1:0] i_reference,
   input  logic                 i_div_valid,
   output logic [DATA_SIZE-1:0] o_reference,
   output logic [DATA_SIZE-1:0] o_error,
   output logic                 o_start,
   output logic                 o_busy,
   output logic                 o_sat,
   output logic                 o_timeout
);

   localparam int unsigned HOLD_W = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
   localparam int unsigned DIFF_W = DATA_SIZE + 1;
   localparam logic signed [DIFF_W-1:0] SAT_HI = DIFF_W'(err_max_f(DATA_SIZE));
   localparam logic signed [DIFF_W-1:0] SAT_LO = DIFF_W'(err_min_f(DATA_SIZE));
   localparam logic [HOLD_W-1:0]        HOLD_LAST = HOLD_W'(START_HOLD - 1);

   state_e                     state_q, state_d;
   logic [HOLD_W-1:0]          hold_q, hold_d;
   logic                       div_q;
   logic                       div_rise_c;
   logic                       timeout_c;
   logic                       clear_c;
   logic                       accum_en_c;
   logic                       load_c;
   logic                       done_c;
   logic [DATA_SIZE-1:0]       avg;
   logic signed [DIFF_W-1:0]   diff_c;
   logic [DATA_SIZE-1:0]       err_c;
   logic                       sat_c;

   iagc_sample_avg #(
      .DATA_SIZE (DATA_SIZE),
      .AVG_LOG2  (AVG_LOG2)
   ) u_avg (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .clear        (clear_c),
      .accum_en     (accum_en_c),
      .sample       (i_sample),
      .sample_valid (i_sample_valid),
      .avg          (avg),
      .done_c       (done_c)
   );

   assign div_rise_c = i_div_valid & ~div_q;

   // Difference in one extra bit so the full unsigned range cannot wrap
   assign diff_c = $signed({1'b0, i_reference}) - $signed({1'b0, avg});

   always_comb begin
      err_c = diff_c[DATA_SIZE-1:0];
      sat_c = 1'b0;
      if (diff_c > SAT_HI) begin
         err_c = SAT_HI[DATA_SIZE-1:0];
         sat_c = 1'b1;
      end else if (diff_c < SAT_LO) begin
         err_c = SAT_LO[DATA_SIZE-1:0];
         sat_c = 1'b1;
      end
   end

   // State register
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
         div_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         div_q   <= i_div_valid;
      end
   end

   // Next-state and control decode
   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      clear_c    = 1'b0;
      accum_en_c = 1'b0;
      load_c     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_enable) begin
               clear_c = 1'b1;
               state_d = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            accum_en_c = 1'b1;
            if (done_c) state_d = ST_CALC;
         end
         ST_CALC: begin
            load_c  = 1'b1;
            hold_d  = '0;
            state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (hold_q == HOLD_LAST) state_d = ST_WAIT;
            else                     hold_d  = hold_q + HOLD_W'(1);
         end
         ST_WAIT: begin
            if (div_rise_c || timeout_c) begin
               clear_c = 1'b1;
               state_d = i_enable ? ST_ACCUM : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Registered outputs; result holds from CALC until the next CALC
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         o_reference <= '0;
         o_error     <= '0;
         o_sat       <= 1'b0;
         o_start     <= 1'b0;
         o_busy      <= 1'b0;
      end else begin
         o_start <= (state_d == ST_ISSUE);
         o_busy  <= (state_d != ST_IDLE);
         if (load_c) begin
            o_reference <= i_reference;
            o_error     <= err_c;
            o_sat       <= sat_c;
         end
      end
   end

`ifdef IAGC_ERRGEN_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q;

   // A real divider edge takes priority over an expiring watchdog
   assign timeout_c = (state_q == ST_WAIT) && !div_rise_c &&
                      (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         wd_q      <= '0;
         o_timeout <= 1'b0;
      end else begin
         o_timeout <= timeout_c;
         if ((state_q == ST_WAIT) && (state_d == ST_WAIT)) wd_q <= wd_q + WD_W'(1);
         else                                              wd_q <= '0;
      end
   end
`else
   logic unused_timeout_cfg;

   assign timeout_c          = 1'b0;
   assign o_timeout          = 1'b0;
   assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

endmodule

// File: tb/tb_iagc_error_gen.sv
// Self-checking bench for iagc_error_gen: vector table plus scoreboard of
// expected divider requests, with hand-written reset/handshake sequences.
module tb_iagc_error_gen;

   localparam int unsigned DW   = 14;
   localparam int unsigned AL   = 4;
   localparam int unsigned HOLD = 10;
   localparam int unsigned TO   = 32;
   localparam int          NBLK = 16;

   typedef struct {
      int ref_v;
      int smp;
      int exp_err;
      int exp_sat;
   } vec_t;

   typedef struct {
      int ref_v;
      int err;
      int sat;
      int cyc;
   } exp_t;

   logic          i_clock = 1'b0;
   logic          i_reset = 1'b0;
   logic          i_enable = 1'b0;
   logic [DW-1:0] i_sample = '0;
   logic          i_sample_valid = 1'b0;
   logic [DW-1:0] i_reference = '0;
   logic          i_div_valid = 1'b0;
   logic [DW-1:0] o_reference;
   logic [DW-1:0] o_error;
   logic          o_start;
   logic          o_busy;
   logic          o_sat;
   logic          o_timeout;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t sbq[$];
   vec_t vecs[6];

   iagc_error_gen #(
      .DATA_SIZE      (DW),
      .AVG_LOG2       (AL),
      .START_HOLD     (HOLD),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .i_clock        (i_clock),
      .i_reset        (i_reset),
      .i_enable       (i_enable),
      .i_sample       (i_sample),
      .i_sample_valid (i_sample_valid),
      .i_reference    (i_reference),
      .i_div_valid    (i_div_valid),
      .o_reference    (o_reference),
      .o_error        (o_error),
      .o_start        (o_start),
      .o_busy         (o_busy),
      .o_sat          (o_sat),
      .o_timeout      (o_timeout)
   );

   always #5 i_clock = ~i_clock;
   always @(posedge i_clock) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: each start rise pops one request; each start pulse width is checked
   bit prev_start = 1'b0;
   int slen = 0;
   always @(negedge i_clock) begin
      exp_t e;
      if (!i_reset) begin
         prev_start = 1'b0;
         slen       = 0;
      end else begin
         if (o_start && !prev_start) begin
            if (sbq.size() == 0) begin
               chk("spurious_start", 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("error", int'($signed(o_error)), e.err);
               chk("sat", int'(o_sat), e.sat);
               chk("reference", int'(o_reference), e.ref_v);
               chk("start_latency", cyc - e.cyc, 2);
            end
         end
         if (o_start) slen++;
         else if (prev_start) begin
            chk("start_len", slen, int'(HOLD));
            slen = 0;
         end
         prev_start = o_start;
      end
   end

   task automatic send_samples(input int v, input int n, input bit gaps, input bit push,
                               input int ref_v, input int exp_err, input int exp_sat,
                               input bit keep_valid);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(posedge i_clock); #1;
         if (gaps && (i % 2 == 1)) begin
            i_sample_valid = 1'b0;
            @(posedge i_clock); #1;
         end
         i_sample       = DW'(v);
         i_sample_valid = 1'b1;
         if (push && (i == n - 1)) begin
            e.ref_v = ref_v; e.err = exp_err; e.sat = exp_sat; e.cyc = cyc;
            sbq.push_back(e);
         end
      end
      @(posedge i_clock); #1;
      i_sample_valid = keep_valid;
   endtask

   task automatic wait_rise();
      int n = 0;
      while (!o_start && n < 200) begin @(negedge i_clock); n++; end
      chk("start_seen", int'(o_start), 1);
   endtask

   task automatic wait_start_done();
      int n = 0;
      wait_rise();
      while (o_start && n < 200) begin @(negedge i_clock); n++; end
      chk("start_dropped", int'(o_start), 0);
   endtask

   task automatic pulse_div();
      @(posedge i_clock); #1; i_div_valid = 1'b1;
      @(posedge i_clock); #1; i_div_valid = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, int'(o_busy), 0);
      chk({tag, "_start"}, int'(o_start), 0);
      chk({tag, "_error"}, int'(o_error), 0);
      chk({tag, "_reference"}, int'(o_reference), 0);
      chk({tag, "_sat"}, int'(o_sat), 0);
   endtask

   initial begin
      vecs[0] = '{4144, 8248, -4104, 0};
      vecs[1] = '{551, 1549, -998, 0};
      vecs[2] = '{16383, 0, 8191, 1};
      vecs[3] = '{0, 16383, -8192, 1};
      vecs[4] = '{8191, 0, 8191, 0};
      vecs[5] = '{0, 8192, -8192, 0};

      // Reset state
      repeat (3) @(negedge i_clock);
      check_all_zero("rst");
      chk("rst_timeout", int'(o_timeout), 0);
      @(posedge i_clock); #1; i_reset = 1'b1;
      repeat (3) @(negedge i_clock);
      chk("idle_no_enable_busy", int'(o_busy), 0);

      // Table-driven blocks, back to back through the divider handshake
      @(posedge i_clock); #1; i_enable = 1'b1;
      for (int v = 0; v < 6; v++) begin
         i_reference = DW'(vecs[v].ref_v);
         send_samples(vecs[v].smp, NBLK, v[0], 1'b1, vecs[v].ref_v,
                      vecs[v].exp_err, vecs[v].exp_sat, 1'b0);
         wait_start_done();
         chk("wait_busy", int'(o_busy), 1);
         pulse_div();
      end

      // Samples during CALC/ISSUE/WAIT ignored; div_valid high on WAIT entry is no edge
      i_reference = DW'(3000);
      send_samples(1000, NBLK, 1'b0, 1'b1, 3000, 2000, 0, 1'b1);
      i_sample    = DW'(16383);
      i_div_valid = 1'b1;
      wait_start_done();
      repeat (30) @(negedge i_clock);
      chk("held_in_wait", int'(o_busy), 1);
      @(posedge i_clock); #1; i_sample_valid = 1'b0; i_div_valid = 1'b0;
      pulse_div();
      send_samples(2000, NBLK, 1'b0, 1'b1, 3000, 1000, 0, 1'b0);
      wait_start_done();
      pulse_div();

      // Reset mid-ACCUM discards the partial block
      i_reference = DW'(100);
      send_samples(50, 7, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      @(posedge i_clock); #2; i_reset = 1'b0;
      #1; check_all_zero("rst_accum");
      @(posedge i_clock); #1; i_reset = 1'b1;
      i_reference = DW'(400);
      send_samples(300, NBLK - 1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      repeat (10) @(negedge i_clock);
      chk("partial_block_busy", int'(o_busy), 1);
      send_samples(300, 1, 1'b0, 1'b1, 400, 100, 0, 1'b0);

      // Reset mid-ISSUE clears the result
      wait_rise();
      repeat (3) @(negedge i_clock);
      @(posedge i_clock); #2; i_reset = 1'b0;
      #1; check_all_zero("rst_issue");
      @(posedge i_clock); #1; i_reset = 1'b1;

      // WAIT with no divider edge
      i_reference = DW'(200);
      send_samples(100, NBLK, 1'b0, 1'b1, 200, 100, 0, 1'b0);
      wait_start_done();
`ifdef IAGC_ERRGEN_TIMEOUT_EN
      begin
         int n = 0;
         while (!o_timeout && n < 200) begin @(negedge i_clock); n++; end
         chk("timeout_delay", n, int'(TO));
         chk("timeout_error_held", int'($signed(o_error)), 100);
         @(negedge i_clock);
         chk("timeout_one_cycle", int'(o_timeout), 0);
         chk("timeout_back_busy", int'(o_busy), 1);
      end
`else
      begin
         int tcount = 0;
         i_sample       = DW'(5);
         i_sample_valid = 1'b1;
         repeat (200) begin
            @(negedge i_clock);
            tcount += int'(o_timeout);
         end
         chk("no_timeout", tcount, 0);
         chk("stuck_in_wait", int'(o_busy), 1);
         @(posedge i_clock); #1; i_sample_valid = 1'b0;
         pulse_div();
         repeat (2) @(negedge i_clock);
         chk("resume_busy", int'(o_busy), 1);
      end
`endif

      repeat (5) @(negedge i_clock);
      chk("scoreboard_empty", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/iagc_error_gen.md
Name: iagc_error_gen

Overview:
Upstream stage of the IAGC divider `processor`. It averages a block of envelope samples and forms the signed error `reference - average`. It then presents the reference/error pair to the divider with a held start strobe and waits for the divider's valid before starting the next block. The averaging block, the start strobe and the divider handshake are all sequenced by a small FSM.

Parameters:
- DATA_SIZE, 14: width of sample, reference and error; must match the divider's DATA_SIZE.
- AVG_LOG2, 4: log2 of samples averaged per block (default 16 samples).
- START_HOLD, 10: number of clock cycles `o_start` is held high per request.
- TIMEOUT_CYCLES, 1024: WAIT watchdog limit; used only with IAGC_ERRGEN_TIMEOUT_EN.

Ports:
- i_clock  in  1  system clock; all logic is on the rising edge.
- i_reset  in  1  asynchronous, active-low reset (0 = reset).
- i_enable  in  1  allows a new block to start; sampled in IDLE only.
- i_sample  in  DATA_SIZE  unsigned envelope magnitude.
- i_sample_valid  in  1  qualifies `i_sample` for one cycle.
- i_reference  in  DATA_SIZE  unsigned target level; sampled at the end of accumulation.
- i_div_valid  in  1  divider `o_valid`; its rising edge ends WAIT.
- o_reference  out  DATA_SIZE  latched reference, to divider `i_reference`.
- o_error  out  DATA_SIZE  signed two's-complement error, to divider `i_error`.
- o_start  out  1  divider start strobe.
- o_busy  out  1  high in every state except IDLE.
- o_sat  out  1  set when the current `o_error` was saturated.
- o_timeout  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset (asynchronous, `i_reset` = 0):
  - FSM goes to IDLE; accumulator, sample counter, hold counter, watchdog and edge-detect register clear.
  - All outputs are 0.
- FSM states: IDLE, ACCUM, CALC, ISSUE, WAIT.
- IDLE: on `i_enable` = 1, clear the accumulator and counter, then go to ACCUM.
- ACCUM:
  - Each cycle with `i_sample_valid` = 1 adds `i_sample` to an accumulator of DATA_SIZE+AVG_LOG2 bits (cannot overflow) and increments the counter.
  - The cycle that accepts sample number 2^AVG_LOG2 goes to CALC.
  - Cycles without valid do nothing.
- CALC (1 cycle):
  - avg = acc >> AVG_LOG2 (truncating).
  - diff = `i_reference` - avg, computed in DATA_SIZE+1 signed bits.
  - Saturate diff to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
  - Register `o_error`, register `o_reference` = `i_reference`, set `o_sat` if clipped, else clear it.
  - Go to ISSUE.
- ISSUE:
  - `o_start` = 1 for exactly START_HOLD cycles, starting the cycle after CALC.
  - Then drop `o_start` and go to WAIT.
- WAIT:
  - On a rising edge of `i_div_valid` (previous 0, current 1): go to ACCUM if `i_enable` = 1, else to IDLE.
  - The accumulator and counter clear on that transition.
- `o_reference` and `o_error` are stable from CALC exit until the next CALC.
- Samples with `i_sample_valid` in CALC, ISSUE or WAIT are dropped and never counted.
- Deasserting `i_enable` mid-block does not abort the block; it is honoured only at WAIT exit or in IDLE.
- `i_div_valid` high already on WAIT entry is not an edge; the block waits for the next rising edge.
- Latency: last sample to `o_start` rise is 2 cycles.
- Reset mid-operation aborts immediately and clears all outputs; no partial result is retained.

Optional Feature:
- Macro: IAGC_ERRGEN_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in WAIT.
  - After TIMEOUT_CYCLES cycles with no edge, pulse `o_timeout` for 1 cycle and leave WAIT with the same `i_enable` rule as a normal exit.
  - `o_error` is held.
- Undefined: WAIT blocks indefinitely; `o_timeout` is tied to 0 and no watchdog logic is instantiated.

Decomposition:
- Package iagc_pkg holds:
  - the state encoding enum;
  - the DATA_SIZE default;
  - the saturation limit constants ERR_MAX and ERR_MIN, derived from DATA_SIZE;
  - the accumulator width function DATA_SIZE+AVG_LOG2.
- One sub-module, iagc_sample_avg: accumulator, sample counter and done flag. The FSM top instantiates it.

Test Plan:
1. Reference 4144 (01000000110000), 16 samples of 8248 -> `o_error` = 10111111111000 (-4104), `o_sat` = 0, `o_start` high 10 cycles beginning 2 cycles after the last sample.
2. Reference 551 (00001000100111), 16 samples of 1549 -> `o_error` = 11110000011010 (-998). Pulse `i_div_valid` -> FSM re-enters ACCUM.
3. Saturation:
   - reference 16383, samples 0 -> `o_error` = 8191, `o_sat` = 1;
   - reference 0, samples 16383 -> `o_error` = -8192 (10000000000000), `o_sat` = 1.
4. Sample valid asserted throughout ISSUE/WAIT, and `i_div_valid` already high on WAIT entry -> those samples are ignored, no exit until a fresh rising edge, next block averages only post-WAIT samples.
5. Drive `i_reset` low mid-ACCUM (after 7 samples) and mid-ISSUE -> all outputs 0 immediately; after release plus `i_enable`, a full 16 new samples are required.
6. With IAGC_ERRGEN_TIMEOUT_EN and TIMEOUT_CYCLES = 32, never assert `i_div_valid` -> `o_timeout` pulses exactly 32 cycles after WAIT entry, then returns to ACCUM. Without the macro, the FSM stays in WAIT indefinitely.
